tlk2711_pattern_checker: RTL and testbench
==========================================

# tlk2711_pattern_checker

Parametrised receive/transmit data-pattern checker for the TLK2711 datapath, the successor of the fixed 16-bit byte-increment FIFO validator. It taps any valid/data stream (TX FIFO output or RX deframer output), checks it against one of three selectable patterns, and self-synchronises where the pattern allows. Frame-aware restart, lock tracking, saturating error/word/frame counters and first-error capture are exposed to the register bank for PS-side BIST readout.

## Interface
Parameters:
- DATA_W, 16: data width in bits; multiple of 8, ≥16.
- CNT_W, 32: width of all statistics counters.
- LOCK_WORDS, 4: consecutive matching words needed SEARCH→LOCKED.
- UNLOCK_ERRS, 8: consecutive errored words needed LOCKED→SEARCH.

Ports:
- clk  in  1  datapath clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- i_soft_rst  in  1  synchronous reset, same effect as rst.
- i_check_ena  in  1  level; low forces IDLE.
- i_mode  in  2  0 legacy byte-increment, 1 word-increment, 2 PRBS-15, 3 reserved (behaves as 0).
- i_frame_len  in  16  words per frame; 0 = unframed.
- i_valid  in  1  data qualifier.
- i_data  in  DATA_W  data under test.
- i_stop  in  1  pulse; restarts pattern as at frame end.
- i_clear_cnt  in  1  pulse; clears counters, sticky flag and capture.
- o_check_error  out  1  per-word mismatch pulse (LOCKED only).
- o_sticky_error  out  1  set on any counted error.
- o_locked  out  1  state == LOCKED.
- o_lock_lost  out  1  one-cycle pulse on LOCKED→SEARCH.
- o_err_cnt, o_word_cnt, o_frame_cnt  out  CNT_W  saturating counters.
- o_first_err_exp, o_first_err_got  out  DATA_W  expected/received at first counted error.
- o_first_err_idx  out  16  in-frame word index of first counted error.

## Operation
- States IDLE, SEARCH, LOCKED. IDLE when i_check_ena=0; pattern generator reset, counters held.
- IDLE→: mode 0 goes directly LOCKED with seed (lane 0 = 0x01, other lanes 0x00); modes 1/2 go SEARCH.
- Mode 0: each byte lane +0x02 per valid word (mod 256). Mode 1: whole word +1 (mod 2^DATA_W). Mode 2: PRBS-15 x^15+x^14+1, DATA_W bits per word, MSB first.
- SEARCH: first valid word loads generator (mode 1: expected = word+1; mode 2: LFSR state = word[DATA_W-1 -: 15] advanced by the remaining bits). Then LOCK_WORDS consecutive matches → LOCKED; any mismatch re-seeds from that word, match count 0.
- LOCKED: mismatch → o_check_error, o_err_cnt++, o_sticky_error=1; UNLOCK_ERRS consecutive errors → SEARCH, o_lock_lost. Generator always advances, errors do not re-seed in LOCKED.
- o_word_cnt counts every valid word when not IDLE. In-frame index wraps at i_frame_len-1; that word increments o_frame_cnt, then mode 0 reseeds (stays LOCKED), modes 1/2 enter SEARCH (no o_lock_lost).
- i_stop: index→0, same restart as frame end, o_frame_cnt not incremented.
- Capture registers load only when o_err_cnt transitions 0→1.
- Counters saturate at all-ones. i_clear_cnt wins over same-cycle increment (result 0); clears capture and sticky, not state.
- i_mode / i_frame_len sampled only in IDLE; changes while active ignored.

## Timing
- i_valid/i_data registered once; compare in next stage: i_valid at cycle n → o_check_error and counter update visible at n+2.
- i_stop and frame-end act on the word after the affected word; i_stop together with a valid word: that word checked against old pattern.
- i_check_ena deassert: IDLE on next cycle; in-flight word discarded.
- All outputs 0 after rst/i_soft_rst; rst asserted mid-frame clears everything asynchronously.

## Structure
- Package tlk2711_chk_pkg: mode localparams, state encoding, PRBS-15 polynomial, function prbs15_adv(state, nbits).
- Sub-module tlk2711_prbs15_par: combinational parallel LFSR, DATA_W output bits + next state.

## Test plan
- Mode 0, DATA_W=16, words 0x0001,0x0203,0x0405… 1000 words → o_err_cnt=0, o_word_cnt=1000, o_locked=1 throughout.
- Mode 2, DATA_W=32, start mid-sequence, inject one bit flip at word 50 → o_locked after 5 words, o_err_cnt=1, capture idx 50, exp/got differ in one bit.
- Mode 1, 12 consecutive corrupted words while LOCKED → o_err_cnt=8, o_lock_lost pulse, relock after 5 clean words.
- Mode 0, i_frame_len=435, 3 frames each restarting at 0x0001 → o_frame_cnt=3, no errors.
- CNT_W=4, 20 errors → o_err_cnt=15; i_clear_cnt with error same cycle → 0.
- rst asserted mid-frame → all outputs 0 same cycle, state IDLE.

Source files
------------

// File: rtl/tlk2711_pattern_checker_pkg.sv
// Shared definitions for the TLK2711 pattern checker: modes, FSM states, PRBS-15 helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: mode codes, state_t, PRBS-15 tap mask, prbs15_adv() serial LFSR advance.
package tlk2711_chk_pkg;

   localparam logic [1:0] MODE_BYTE = 2'd0;
   localparam logic [1:0] MODE_WORD = 2'd1;
   localparam logic [1:0] MODE_PRBS = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // x^15 + x^14 + 1: state[14] holds the oldest bit, state[0] the newest,
   // so the next bit is state[14] ^ state[13].
   localparam logic [14:0] PRBS15_TAPS = 15'h6000;

   // Advance the LFSR by nbits serial steps; nbits is constant at every call site.
   function automatic logic [14:0] prbs15_adv(input logic [14:0] state, input int nbits);
      logic [14:0] s;
      s = state;
      for (int i = 0; i < nbits; i++) begin
         s = {s[13:0], ^(s & PRBS15_TAPS)};
      end
      return s;
   endfunction

endpackage

// File: rtl/tlk2711_pattern_checker_if.sv
// Data stream tapped by the pattern checker (TX FIFO output or RX deframer output).
// Latency: n/a (wires only).
// Backpressure: none; the checker is a passive tap, valid alone qualifies data.
// Signals: valid - word qualifier; data - DATA_W-bit word under test.
interface tlk2711_pattern_checker_if #(
   parameter int DATA_W = 16
);
   logic              valid;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data);
   modport slave  (input  valid, input  data);
endinterface

// File: rtl/tlk2711_pattern_checker_prbs15_par.sv
// Parallel PRBS-15 generator: DATA_W output bits (MSB first) plus successor state.
// Latency: combinational.
// Backpressure: n/a; caller decides when to load next_state.
// Ports: state in (15), dat out (DATA_W), next_state out (15).
module tlk2711_prbs15_par
   import tlk2711_chk_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [14:0]       state,
   output logic [DATA_W-1:0] dat,
   output logic [14:0]       next_state
);

   logic [14:0] s;

   always_comb begin
      s   = state;
      dat = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         dat[i] = ^(s & PRBS15_TAPS);
         s      = {s[13:0], dat[i]};
      end
      next_state = s;
   end

endmodule

// File: rtl/tlk2711_pattern_checker.sv
// Pattern checker: byte-increment / word-increment / PRBS-15 with lock tracking and BIST counters.
// Latency: valid word at cycle n -> o_check_error and counters at n+2.
// Backpressure: none; every valid word is checked, the tap never stalls the stream.
// Ports: clk, rst (async high), i_soft_rst, i_check_ena, i_mode, i_frame_len, s_in (valid/data),
//        i_stop, i_clear_cnt; o_check_error, o_sticky_error, o_locked, o_lock_lost,
//        o_err_cnt/o_word_cnt/o_frame_cnt, o_first_err_exp/got/idx.
module tlk2711_pattern_checker
   import tlk2711_chk_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int CNT_W       = 32,
   parameter int LOCK_WORDS  = 4,
   parameter int UNLOCK_ERRS = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_soft_rst,
   input  logic                      i_check_ena,
   input  logic [1:0]                i_mode,
   input  logic [15:0]               i_frame_len,
   tlk2711_pattern_checker_if.slave  s_in,
   input  logic                      i_stop,
   input  logic                      i_clear_cnt,
   output logic                      o_check_error,
   output logic                      o_sticky_error,
   output logic                      o_locked,
   output logic                      o_lock_lost,
   output logic [CNT_W-1:0]          o_err_cnt,
   output logic [CNT_W-1:0]          o_word_cnt,
   output logic [CNT_W-1:0]          o_frame_cnt,
   output logic [DATA_W-1:0]         o_first_err_exp,
   output logic [DATA_W-1:0]         o_first_err_got,
   output logic [15:0]               o_first_err_idx
);

   localparam int MCNT_W = $clog2(LOCK_WORDS + 1);
   localparam int ECNT_W = $clog2(UNLOCK_ERRS + 1);
   localparam logic [DATA_W-1:0] SEED0 = DATA_W'(1);

   function automatic logic [DATA_W-1:0] lane_add2(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int l = 0; l < DATA_W / 8; l++) begin
         r[l*8 +: 8] = w[l*8 +: 8] + 8'd2;
      end
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic [ECNT_W-1:0] ecnt_q, ecnt_d;
   logic              seeded_q, seeded_d;

   logic [1:0]        mode_q, mode_in;
   logic [15:0]       flen_q, idx_q;
   logic              v_q, stop_q;
   logic [DATA_W-1:0] d_q, exp_q, exp_w, prbs_dat;
   logic [14:0]       lfsr_q, prbs_next;
   logic              act, wv, match, frame_end, restart;
   logic              seed_now, adv_now, err_evt, lock_lost_d;

   tlk2711_prbs15_par #(.DATA_W(DATA_W)) u_prbs (
      .state      (lfsr_q),
      .dat        (prbs_dat),
      .next_state (prbs_next)
   );

   assign mode_in   = (i_mode == 2'd3) ? MODE_BYTE : i_mode;
   assign act       = i_check_ena && (state_q != ST_IDLE);
   assign wv        = act && v_q;
   assign exp_w     = (mode_q == MODE_PRBS) ? prbs_dat : exp_q;
   assign match     = (d_q == exp_w);
   assign frame_end = wv && (flen_q != 16'd0) && (idx_q == flen_q - 16'd1);
   // The word carrying stop / closing the frame is checked first; the restart hits the next one.
   assign restart   = act && (stop_q || frame_end);
   assign o_locked  = (state_q == ST_LOCKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mcnt_q   <= '0;
         ecnt_q   <= '0;
         seeded_q <= 1'b0;
      end else if (i_soft_rst) begin
         state_q  <= ST_IDLE;
         mcnt_q   <= '0;
         ecnt_q   <= '0;
         seeded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcnt_q   <= mcnt_d;
         ecnt_q   <= ecnt_d;
         seeded_q <= seeded_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mcnt_d      = mcnt_q;
      ecnt_d      = ecnt_q;
      seeded_d    = seeded_q;
      seed_now    = 1'b0;
      adv_now     = 1'b0;
      err_evt     = 1'b0;
      lock_lost_d = 1'b0;
      if (!i_check_ena) begin
         state_d  = ST_IDLE;
         mcnt_d   = '0;
         ecnt_d   = '0;
         seeded_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Byte mode has a known absolute seed, so it needs no search.
               state_d  = (mode_in == MODE_BYTE) ? ST_LOCKED : ST_SEARCH;
               mcnt_d   = '0;
               ecnt_d   = '0;
               seeded_d = 1'b0;
            end
            ST_SEARCH: begin
               if (v_q) begin
                  if (!seeded_q || !match) begin
                     seed_now = 1'b1;
                     seeded_d = 1'b1;
                     mcnt_d   = '0;
                  end else begin
                     adv_now = 1'b1;
                     if (mcnt_q == MCNT_W'(LOCK_WORDS - 1)) begin
                        state_d = ST_LOCKED;
                        mcnt_d  = '0;
                        ecnt_d  = '0;
                     end else begin
                        mcnt_d = mcnt_q + MCNT_W'(1);
                     end
                  end
               end
            end
            ST_LOCKED: begin
               if (v_q) begin
                  // Free-running in lock: a corrupted word never disturbs the generator.
                  adv_now = 1'b1;
                  if (match) begin
                     ecnt_d = '0;
                  end else begin
                     err_evt = 1'b1;
                     if (ecnt_q == ECNT_W'(UNLOCK_ERRS - 1)) begin
                        state_d     = ST_SEARCH;
                        lock_lost_d = 1'b1;
                        seeded_d    = 1'b0;
                        mcnt_d      = '0;
                        ecnt_d      = '0;
                     end else begin
                        ecnt_d = ecnt_q + ECNT_W'(1);
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (restart) begin
            state_d  = (mode_q == MODE_BYTE) ? ST_LOCKED : ST_SEARCH;
            mcnt_d   = '0;
            ecnt_d   = '0;
            seeded_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || i_soft_rst) begin
         v_q <= 1'b0;  stop_q <= 1'b0;  d_q <= '0;
         exp_q <= SEED0;  lfsr_q <= '1;
         mode_q <= MODE_BYTE;  flen_q <= '0;  idx_q <= '0;
         o_check_error <= 1'b0;  o_lock_lost <= 1'b0;  o_sticky_error <= 1'b0;
         o_err_cnt <= '0;  o_word_cnt <= '0;  o_frame_cnt <= '0;
         o_first_err_exp <= '0;  o_first_err_got <= '0;  o_first_err_idx <= '0;
      end else begin
         v_q           <= s_in.valid & i_check_ena;
         stop_q        <= i_stop & i_check_ena;
         d_q           <= s_in.data;
         o_check_error <= err_evt;
         o_lock_lost   <= lock_lost_d;

         if (state_q == ST_IDLE) begin
            mode_q <= mode_in;
            flen_q <= i_frame_len;
            exp_q  <= SEED0;
            lfsr_q <= '1;
            idx_q  <= '0;
         end else if (act) begin
            if (restart) begin
               idx_q <= '0;
               if (mode_q == MODE_BYTE) exp_q <= SEED0;
            end else begin
               if (wv) idx_q <= idx_q + 16'd1;
               if (seed_now) begin
                  case (mode_q)
                     MODE_WORD: exp_q  <= d_q + DATA_W'(1);
                     MODE_PRBS: lfsr_q <= prbs15_adv(d_q[DATA_W-1 -: 15], DATA_W - 15);
                     default:   exp_q  <= lane_add2(d_q);
                  endcase
               end else if (adv_now) begin
                  case (mode_q)
                     MODE_WORD: exp_q  <= exp_q + DATA_W'(1);
                     MODE_PRBS: lfsr_q <= prbs_next;
                     default:   exp_q  <= lane_add2(exp_q);
                  endcase
               end
            end
         end

         // Clear beats any same-cycle increment.
         if (i_clear_cnt) begin
            o_err_cnt <= '0;  o_word_cnt <= '0;  o_frame_cnt <= '0;  o_sticky_error <= 1'b0;
            o_first_err_exp <= '0;  o_first_err_got <= '0;  o_first_err_idx <= '0;
         end else begin
            if (err_evt && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + CNT_W'(1);
            if (wv && (o_word_cnt != '1)) o_word_cnt <= o_word_cnt + CNT_W'(1);
            if (frame_end && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            if (err_evt) o_sticky_error <= 1'b1;
            if (err_evt && (o_err_cnt == '0)) begin
               o_first_err_exp <= exp_w;
               o_first_err_got <= d_q;
               o_first_err_idx <= idx_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_tlk2711_pattern_checker.sv
// Bench for tlk2711_pattern_checker: 16-bit instance (modes 0/1) and 32-bit, 4-bit-counter instance (PRBS).
// Latency: scoreboard entries resolve two clocks after the word is driven.
// Backpressure: none; the stream is driven freely.
module tb_tlk2711_pattern_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, soft_rst, ena_a, ena_b, stop, clr;
   logic [1:0]  mode;
   logic [15:0] flen;

   logic        a_err, a_sticky, a_locked, a_lost;
   logic [31:0] a_err_cnt, a_word_cnt, a_frame_cnt;
   logic [15:0] a_fexp, a_fgot, a_fidx;
   logic        b_err, b_sticky, b_locked, b_lost;
   logic [3:0]  b_err_cnt, b_word_cnt, b_frame_cnt;
   logic [31:0] b_fexp, b_fgot;
   logic [15:0] b_fidx;

   tlk2711_pattern_checker_if #(.DATA_W(16)) ifa ();
   tlk2711_pattern_checker_if #(.DATA_W(32)) ifb ();

   tlk2711_pattern_checker #(.DATA_W(16), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .i_soft_rst(soft_rst), .i_check_ena(ena_a), .i_mode(mode),
      .i_frame_len(flen), .s_in(ifa), .i_stop(stop), .i_clear_cnt(clr),
      .o_check_error(a_err), .o_sticky_error(a_sticky), .o_locked(a_locked), .o_lock_lost(a_lost),
      .o_err_cnt(a_err_cnt), .o_word_cnt(a_word_cnt), .o_frame_cnt(a_frame_cnt),
      .o_first_err_exp(a_fexp), .o_first_err_got(a_fgot), .o_first_err_idx(a_fidx));

   tlk2711_pattern_checker #(.DATA_W(32), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .i_soft_rst(soft_rst), .i_check_ena(ena_b), .i_mode(mode),
      .i_frame_len(flen), .s_in(ifb), .i_stop(stop), .i_clear_cnt(clr),
      .o_check_error(b_err), .o_sticky_error(b_sticky), .o_locked(b_locked), .o_lock_lost(b_lost),
      .o_err_cnt(b_err_cnt), .o_word_cnt(b_word_cnt), .o_frame_cnt(b_frame_cnt),
      .o_first_err_exp(b_fexp), .o_first_err_got(b_fgot), .o_first_err_idx(b_fidx));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Per-word scoreboard: expected check_error, locked and lock_lost once the word resolves.
   typedef struct packed {logic err; logic lock; logic lost;} sb_t;
   sb_t qa[$];
   sb_t qb[$];
   sb_t ea, eb;
   logic a_d1 = 1'b0, a_d2 = 1'b0, b_d1 = 1'b0, b_d2 = 1'b0;

   always @(posedge clk) begin
      a_d1 <= ifa.valid & ena_a;  a_d2 <= a_d1;
      b_d1 <= ifb.valid & ena_b;  b_d2 <= b_d1;
   end

   always @(negedge clk) begin
      if (a_d2) begin
         if (qa.size() == 0) chk("sb_a_underrun", 64'd1, 64'd0);
         else begin
            ea = qa.pop_front();
            chk("a_err", a_err, ea.err);
            chk("a_lock", a_locked, ea.lock);
            chk("a_lost", a_lost, ea.lost);
         end
      end
      if (b_d2) begin
         if (qb.size() == 0) chk("sb_b_underrun", 64'd1, 64'd0);
         else begin
            eb = qb.pop_front();
            chk("b_err", b_err, eb.err);
            chk("b_lock", b_locked, eb.lock);
            chk("b_lost", b_lost, eb.lost);
         end
      end
   end

   task automatic send_a(input logic [15:0] w, input logic e, input logic l, input logic lo, input logic st);
      @(posedge clk); #1;
      ifa.valid = 1'b1;  ifa.data = w;  stop = st;
      qa.push_back({e, l, lo});
   endtask

   task automatic send_b(input logic [31:0] w, input logic e, input logic l, input logic lo);
      @(posedge clk); #1;
      ifb.valid = 1'b1;  ifb.data = w;  stop = 1'b0;
      qb.push_back({e, l, lo});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         ifa.valid = 1'b0;  ifb.valid = 1'b0;  stop = 1'b0;
      end
   endtask

   // PRBS-15 reference: b[n] = b[n-15] ^ b[n-14]; hist[14] is b[n-15], hist[0] is b[n-1].
   logic [14:0] hist = 15'h1ACE;
   task automatic gen_word(output logic [31:0] w);
      logic b;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         b    = hist[14] ^ hist[13];
         hist = {hist[13:0], b};
         w    = {w[30:0], b};
      end
   endtask

   function automatic logic [15:0] byte_word(input int k);
      return {8'(2 * k), 8'(2 * k + 1)};
   endfunction

   logic [15:0] base, bad_w;
   logic [31:0] w32, clean50;

   initial begin
      rst = 1'b1;  soft_rst = 1'b0;  ena_a = 1'b0;  ena_b = 1'b0;
      mode = 2'd0;  flen = 16'd0;  stop = 1'b0;  clr = 1'b0;
      ifa.valid = 1'b0;  ifa.data = '0;  ifb.valid = 1'b0;  ifb.data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_locked", a_locked, 0);
      chk("rst_err_cnt", a_err_cnt, 0);
      chk("rst_word_cnt", a_word_cnt, 0);
      chk("rst_chk_err", a_err, 0);
      chk("rst_b_fexp", b_fexp, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Byte-increment, unframed, 1000 clean words.
      mode = 2'd0;  ena_a = 1'b1;
      idle(2);
      @(negedge clk) chk("m0_lock_start", a_locked, 1);
      for (int k = 0; k < 1000; k++) send_a(byte_word(k), 1'b0, 1'b1, 1'b0, 1'b0);
      idle(4);
      @(negedge clk);
      chk("m0_err_cnt", a_err_cnt, 0);
      chk("m0_word_cnt", a_word_cnt, 1000);
      chk("m0_frame_cnt", a_frame_cnt, 0);

      // Word-increment: lock, 12 corrupted words, relock.
      ena_a = 1'b0;  idle(2);
      mode = 2'd1;  clr = 1'b1;  idle(1);
      clr = 1'b0;  ena_a = 1'b1;  idle(1);
      @(negedge clk);
      chk("m1_search", a_locked, 0);
      chk("m1_cleared", a_word_cnt, 0);
      base = 16'h1230;
      for (int i = 0; i < 10; i++) send_a(base + 16'(i), 1'b0, i >= 4, 1'b0, 1'b0);
      for (int j = 0; j < 12; j++) send_a(~(base + 16'(10 + j)), j < 8, j <= 6, j == 7, 1'b0);
      for (int i = 0; i < 8; i++) send_a(base + 16'(22 + i), 1'b0, i >= 4, 1'b0, 1'b0);
      idle(4);
      @(negedge clk);
      bad_w = ~(base + 16'd10);
      chk("m1_err_cnt", a_err_cnt, 8);
      chk("m1_sticky", a_sticky, 1);
      chk("m1_word_cnt", a_word_cnt, 30);
      chk("m1_first_idx", a_fidx, 10);
      chk("m1_first_exp", a_fexp, base + 16'd10);
      chk("m1_first_got", a_fgot, bad_w);

      // Byte-increment, 435-word frames, then a stop mid-frame.
      ena_a = 1'b0;  idle(2);
      mode = 2'd0;  flen = 16'd435;  clr = 1'b1;  idle(1);
      clr = 1'b0;  ena_a = 1'b1;  idle(1);
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 435; k++) send_a(byte_word(k), 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) send_a(byte_word(k), 1'b0, 1'b1, 1'b0, k == 9);
      for (int k = 0; k < 5; k++) send_a(byte_word(k), 1'b0, 1'b1, 1'b0, 1'b0);
      idle(4);
      @(negedge clk);
      chk("fr_frame_cnt", a_frame_cnt, 3);
      chk("fr_err_cnt", a_err_cnt, 0);
      chk("fr_word_cnt", a_word_cnt, 1320);

      // PRBS-15 on 32-bit lanes, joined mid-sequence, one bit flip at word 50.
      ena_a = 1'b0;  idle(2);
      mode = 2'd2;  flen = 16'd0;  clr = 1'b1;  idle(1);
      clr = 1'b0;  ena_b = 1'b1;  idle(1);
      repeat (7) gen_word(w32);
      clean50 = '0;
      for (int i = 0; i < 60; i++) begin
         gen_word(w32);
         if (i == 50) begin
            clean50 = w32;
            w32 = w32 ^ 32'h20;
         end
         send_b(w32, i == 50, i >= 4, 1'b0);
      end
      idle(4);
      @(negedge clk);
      chk("p_err_cnt", b_err_cnt, 1);
      chk("p_first_idx", b_fidx, 50);
      chk("p_first_exp", b_fexp, clean50);
      chk("p_first_got", b_fgot, clean50 ^ 32'h20);
      chk("p_word_sat", b_word_cnt, 4'hF);

      // 20 isolated errors saturate a 4-bit counter without losing lock.
      clr = 1'b1;  idle(1);
      clr = 1'b0;
      for (int i = 0; i < 40; i++) begin
         gen_word(w32);
         if (i % 2 == 1) w32 = w32 ^ 32'h1;
         send_b(w32, i % 2 == 1, 1'b1, 1'b0);
      end
      idle(4);
      @(negedge clk);
      chk("sat_err_cnt", b_err_cnt, 4'hF);
      chk("sat_sticky", b_sticky, 1);

      // Clear arriving in the same cycle as an error increment.
      gen_word(w32);
      send_b(w32 ^ 32'h1, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      ifb.valid = 1'b0;  clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      idle(3);
      @(negedge clk);
      chk("clr_same_err_cnt", b_err_cnt, 0);
      chk("clr_same_sticky", b_sticky, 0);
      chk("clr_same_fidx", b_fidx, 0);

      // Synchronous soft reset.
      soft_rst = 1'b1;  idle(1);
      soft_rst = 1'b0;
      @(negedge clk);
      chk("srst_word_cnt", b_word_cnt, 0);
      chk("srst_locked", b_locked, 0);
      ena_b = 1'b0;  idle(2);

      // Asynchronous reset in the middle of a frame.
      mode = 2'd0;  flen = 16'd435;  ena_a = 1'b1;  idle(2);
      for (int k = 0; k < 20; k++) send_a(byte_word(k), 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      @(negedge clk);
      chk("ar_pre_words", a_word_cnt, 20);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("ar_word_cnt", a_word_cnt, 0);
      chk("ar_locked", a_locked, 0);
      chk("ar_frame_cnt", a_frame_cnt, 0);
      chk("ar_chk_err", a_err, 0);
      @(posedge clk); #1 rst = 1'b0;
      ena_a = 1'b0;
      idle(2);

      chk("sb_a_left", qa.size(), 0);
      chk("sb_b_left", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
